// File: rtl/merge_pass_ctrl.sv
// Sequencer for one merge pass: merges pair_count pairs of sorted runs from two
// first-word-fall-through FIFOs into one output FIFO, draining the leftover run.
module merge_pass_ctrl #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  run_len,
  input  logic [LEN_W-1:0]  pair_count,
  input  logic [DATA_W-1:0] din_1,
  input  logic              valid_1,
  input  logic [DATA_W-1:0] din_2,
  input  logic              valid_2,
  input  logic              full,
  output logic [DATA_W-1:0] dout,
  output logic              enq,
  output logic              deq_1,
  output logic              deq_2,
  output logic              last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MERGE   = 3'd1,
    S_DRAIN_1 = 3'd2,
    S_DRAIN_2 = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_rem_1;
  logic [LEN_W-1:0]   r_rem_2;
  logic [LEN_W-1:0]   r_pairs_left;
  logic [LEN_W-1:0]   r_len_q;
  logic               r_busy;
  logic               r_done;

  logic               w_sel1;
  logic               w_xfer;
  logic               w_deq_1;
  logic               w_deq_2;
  logic               w_last;
  logic [DATA_W-1:0]  w_dout;

  // Transfer decode: ties select FIFO 2; rst blocks every handshake.
  always_comb begin
    w_sel1  = (din_1 < din_2);
    w_xfer  = 1'b0;
    w_deq_1 = 1'b0;
    w_deq_2 = 1'b0;
    w_last  = 1'b0;
    w_dout  = din_2;
    case (r_state)
      S_MERGE: begin
        w_xfer  = !rst && !full && valid_1 && valid_2;
        w_dout  = w_sel1 ? din_1 : din_2;
        w_deq_1 = w_xfer && w_sel1;
        w_deq_2 = w_xfer && !w_sel1;
      end
      S_DRAIN_1: begin
        w_xfer  = !rst && !full && valid_1;
        w_dout  = din_1;
        w_deq_1 = w_xfer;
        w_last  = w_xfer && (r_rem_1 == LEN_W'(1));
      end
      S_DRAIN_2: begin
        w_xfer  = !rst && !full && valid_2;
        w_dout  = din_2;
        w_deq_2 = w_xfer;
        w_last  = w_xfer && (r_rem_2 == LEN_W'(1));
      end
      default: begin
        w_xfer = 1'b0;
      end
    endcase
  end

  assign dout  = w_dout;
  assign enq   = w_xfer;
  assign deq_1 = w_deq_1;
  assign deq_2 = w_deq_2;
  assign last  = w_last;
  assign busy  = r_busy;
  assign done  = r_done;

  // Pass state machine with per-run counters and registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rem_1      <= '0;
      r_rem_2      <= '0;
      r_pairs_left <= '0;
      r_len_q      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_len_q      <= run_len;
            r_pairs_left <= pair_count;
            if ((run_len == '0) || (pair_count == '0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_rem_1 <= run_len;
              r_rem_2 <= run_len;
              r_state <= S_MERGE;
              r_busy  <= 1'b1;
            end
          end
        end
        S_MERGE: begin
          if (w_xfer && w_sel1) begin
            r_rem_1 <= r_rem_1 - LEN_W'(1);
            if (r_rem_1 == LEN_W'(1)) r_state <= S_DRAIN_2;
          end else if (w_xfer) begin
            r_rem_2 <= r_rem_2 - LEN_W'(1);
            if (r_rem_2 == LEN_W'(1)) r_state <= S_DRAIN_1;
          end
        end
        S_DRAIN_1, S_DRAIN_2: begin
          if (w_xfer) begin
            if (r_state == S_DRAIN_1) r_rem_1 <= r_rem_1 - LEN_W'(1);
            else                      r_rem_2 <= r_rem_2 - LEN_W'(1);
            // w_last marks the final element of this merged run
            if (w_last) begin
              r_pairs_left <= r_pairs_left - LEN_W'(1);
              if (r_pairs_left == LEN_W'(1)) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_rem_1 <= r_len_q;
                r_rem_2 <= r_len_q;
                r_state <= S_MERGE;
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_merge_pass_ctrl.sv
// Bench for merge_pass_ctrl: FIFO environment, merge-level reference model,
// per-cycle compare process, and directed plus randomized passes.
module tb_merge_pass_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] run_len = 16'd0;
  logic [15:0] pair_count = 16'd0;
  logic [31:0] din_1 = 32'd0;
  logic        valid_1 = 1'b0;
  logic [31:0] din_2 = 32'd0;
  logic        valid_2 = 1'b0;
  logic        full = 1'b0;
  logic [31:0] dout;
  logic        enq, deq_1, deq_2, last, busy, done;

  merge_pass_ctrl #(.DATA_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .run_len(run_len), .pair_count(pair_count),
    .din_1(din_1), .valid_1(valid_1), .din_2(din_2), .valid_2(valid_2), .full(full),
    .dout(dout), .enq(enq), .deq_1(deq_1), .deq_2(deq_2), .last(last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] val; int src; bit lst; } ent_t;
  localparam int M_IDLE = 0, M_ACT = 1, M_DONE = 2;

  int n_checks = 0, n_fail = 0;
  logic [31:0] f1[$], f2[$];
  ent_t exp_q[$];
  int m_mode = M_IDLE, m_len = 0, a_left = 0, b_left = 0, pairs_rem = 0;
  logic [31:0] cap_q[$];
  bit cap_last[$];
  int cap_src[$], cap_cyc[$];
  int done_cnt = 0, cyc = 0, stall_mode = 0;
  bit g1 = 1'b1, g2 = 1'b1;
  bit e_enq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference merge of each run pair, from the FIFO contents at start.
  task automatic build_exp(input int L, input int P);
    int i, j;
    exp_q.delete();
    if (f1.size() < L * P || f2.size() < L * P) begin
      n_checks++; n_fail++;
      $display("FAIL model_load: fifo sizes %0d/%0d, need %0d", f1.size(), f2.size(), L * P);
    end else begin
      for (int p = 0; p < P; p++) begin
        i = 0; j = 0;
        while (i < L || j < L) begin
          ent_t e;
          if (j >= L || (i < L && f1[p*L+i] < f2[p*L+j])) begin
            e.val = f1[p*L+i]; e.src = 1; i++;
          end else begin
            e.val = f2[p*L+j]; e.src = 2; j++;
          end
          e.lst = (i == L && j == L);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Compare process: checks outputs against the model, then advances FIFOs and model.
  always @(negedge clk) begin
    e_enq = (m_mode == M_ACT) && !rst && !full &&
            (a_left == 0 || valid_1) && (b_left == 0 || valid_2);
    chk("busy", busy, m_mode == M_ACT);
    chk("done", done, m_mode == M_DONE);
    if (e_enq && exp_q.size() > 0) begin
      chk("enq", enq, 1'b1);
      chk("dout", dout, exp_q[0].val);
      chk("deq_1", deq_1, exp_q[0].src == 1);
      chk("deq_2", deq_2, exp_q[0].src == 2);
      chk("last", last, exp_q[0].lst);
    end else begin
      chk("enq_idle", enq, 1'b0);
      chk("deq_1_idle", deq_1, 1'b0);
      chk("deq_2_idle", deq_2, 1'b0);
    end
    if (deq_1 && f1.size() > 0) void'(f1.pop_front());
    if (deq_2 && f2.size() > 0) void'(f2.pop_front());
    if (enq) begin
      cap_q.push_back(dout); cap_last.push_back(last);
      cap_src.push_back(deq_1 ? 1 : 2); cap_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (rst) begin
      m_mode = M_IDLE; exp_q.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          if (run_len == 16'd0 || pair_count == 16'd0) m_mode = M_DONE;
          else begin
            m_len = int'(run_len); a_left = m_len; b_left = m_len;
            pairs_rem = int'(pair_count);
            build_exp(m_len, pairs_rem);
            m_mode = M_ACT;
          end
        end
        M_ACT: if (e_enq && exp_q.size() > 0) begin
          if (exp_q[0].src == 1) a_left--; else b_left--;
          void'(exp_q.pop_front());
          if (a_left == 0 && b_left == 0) begin
            pairs_rem--;
            if (pairs_rem == 0) m_mode = M_DONE;
            else begin a_left = m_len; b_left = m_len; end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic step(input logic s, input logic r);
    @(posedge clk); #1;
    cyc++;
    start = s; rst = r;
    case (stall_mode)
      1: begin
        full = ($urandom_range(0, 3) == 0);
        g1 = ($urandom_range(0, 3) != 0);
        g2 = ($urandom_range(0, 3) != 0);
      end
      2: begin
        full = (cyc >= 3 && cyc <= 5);
        g1 = 1'b1;
        g2 = !(cyc >= 8 && cyc <= 9);
      end
      default: begin full = 1'b0; g1 = 1'b1; g2 = 1'b1; end
    endcase
    valid_1 = g1 && (f1.size() > 0);
    valid_2 = g2 && (f2.size() > 0);
    din_1 = (f1.size() > 0) ? f1[0] : $urandom;
    din_2 = (f2.size() > 0) ? f2[0] : $urandom;
    @(negedge clk); #1;
  endtask

  task automatic clear_cap();
    cap_q.delete(); cap_last.delete(); cap_src.delete(); cap_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic do_pass(input int L, input int P, input int sm);
    int budget;
    clear_cap();
    stall_mode = sm; cyc = 0;
    run_len = 16'(L); pair_count = 16'(P);
    step(1'b1, 1'b0);
    budget = 0;
    do begin step(1'b0, 1'b0); budget++; end
    while (m_mode != M_IDLE && budget < 3000);
    if (budget >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL pass_timeout: no return to idle after %0d cycles, L=%0d P=%0d", budget, L, P);
    end
  endtask

  task automatic push_runs(input int L, input int P);
    int v;
    for (int p = 0; p < P; p++) begin
      v = $urandom_range(0, 15);
      for (int k = 0; k < L; k++) begin f1.push_back(32'(v)); v += $urandom_range(0, 3); end
      v = $urandom_range(0, 15);
      for (int k = 0; k < L; k++) begin f2.push_back(32'(v)); v += $urandom_range(0, 3); end
    end
  endtask

  task automatic load_basic();
    f1.delete(); f2.delete();
    f1 = '{32'd1, 32'd4, 32'd6, 32'd9};
    f2 = '{32'd2, 32'd3, 32'd7, 32'd8};
  endtask

  task automatic check_basic(input string tag);
    logic [31:0] want[8];
    want = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd7, 32'd8, 32'd9};
    chk({tag, "_count"}, cap_q.size(), 8);
    if (cap_q.size() == 8)
      for (int k = 0; k < 8; k++) begin
        chk({tag, "_order"}, cap_q[k], want[k]);
        chk({tag, "_last"}, cap_last[k], k == 7);
      end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int src_want[12];
    int val_want[12];
    int budget;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_enq", enq, 1'b0);
    step(1'b0, 1'b0);

    // Basic merge: eight back-to-back transfers.
    load_basic();
    do_pass(4, 1, 0);
    check_basic("basic");
    if (cap_cyc.size() == 8) chk("basic_consecutive", cap_cyc[7] - cap_cyc[0], 7);

    // Early exhaustion, then ties resolved toward FIFO 2.
    f1 = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd6, 32'd7};
    f2 = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd8, 32'd9};
    val_want = '{1, 2, 3, 5, 5, 5, 5, 5, 6, 7, 8, 9};
    src_want = '{1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 2, 2};
    do_pass(3, 2, 0);
    chk("tie_count", cap_q.size(), 12);
    if (cap_q.size() == 12)
      for (int k = 0; k < 12; k++) begin
        chk("tie_val", cap_q[k], 32'(val_want[k]));
        chk("tie_src", cap_src[k], src_want[k]);
        chk("tie_last", cap_last[k], (k == 5 || k == 11));
      end
    chk("tie_done_cnt", done_cnt, 1);

    // Multi-pair with the next runs already visible.
    f1.delete(); f2.delete();
    push_runs(2, 3);
    do_pass(2, 3, 0);
    chk("multi_count", cap_q.size(), 12);
    if (cap_q.size() == 12)
      for (int k = 0; k < 12; k++) chk("multi_last", cap_last[k], (k % 4) == 3);
    chk("multi_done_cnt", done_cnt, 1);

    // Backpressure: full and an empty FIFO 2 mid-run.
    load_basic();
    do_pass(4, 1, 2);
    check_basic("bp");

    // Degenerate starts.
    do_pass(0, 5, 0);
    chk("zero_len_xfers", cap_q.size(), 0);
    chk("zero_len_done", done_cnt, 1);
    do_pass(4, 0, 0);
    chk("zero_pair_xfers", cap_q.size(), 0);
    chk("zero_pair_done", done_cnt, 1);

    // Reset after the third transfer abandons the pass.
    load_basic();
    clear_cap();
    stall_mode = 0; cyc = 0;
    run_len = 16'd4; pair_count = 16'd1;
    step(1'b1, 1'b0);
    budget = 0;
    while (cap_q.size() < 3 && budget < 50) begin step(1'b0, 1'b0); budget++; end
    chk("rst_reached_3", cap_q.size(), 3);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("rst_busy_after", busy, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_extra_xfer", cap_q.size(), 3);
    load_basic();
    do_pass(4, 1, 0);
    check_basic("post_rst");

    // Randomized passes with random stalls.
    for (int t = 0; t < 20; t++) begin
      int L, P;
      L = $urandom_range(1, 6); P = $urandom_range(1, 4);
      f1.delete(); f2.delete();
      push_runs(L, P);
      do_pass(L, P, 1);
      chk("rand_count", cap_q.size(), 2 * L * P);
      chk("rand_done_cnt", done_cnt, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
